line_filler: RTL

//  Write-side companion to the scanline feeder: during horizontal blanking, fetches
//  one scanline of pixel words from video memory over a Wishbone-style read master and

---
 rtl/line_filler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/line_filler.sv
// ============================================================================
// Module      : line_filler
// Description : Fetches one scanline from video memory during blanking and
//               writes it into the line buffer from address 0 upward.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_filler #(
  parameter int AW   = 24,
  parameter int DW   = 16,
  parameter int LBAW = 9
) (
  input  logic            dotclk_i,
  input  logic            rst_i,
  input  logic            scanline_en_i,
  input  logic            start_i,
  input  logic [AW-1:0]   base_i,
  input  logic [LBAW:0]   words_i,
  output logic            m_cyc_o,
  output logic            m_stb_o,
  output logic [AW-1:0]   m_adr_o,
  input  logic            m_ack_i,
  input  logic [DW-1:0]   m_dat_i,
  output logic            lb_we_o,
  output logic [LBAW-1:0] lb_adr_o,
  output logic [DW-1:0]   lb_dat_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            underrun_o
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              bus_q, bus_d;
  logic [AW-1:0]     adr_q, adr_d;
  logic [LBAW:0]     remaining_q, remaining_d;
  logic [LBAW-1:0]   index_q, index_d;
  logic              lb_we_q, lb_we_d;
  logic [LBAW-1:0]   lb_adr_q, lb_adr_d;
  logic [DW-1:0]     lb_dat_q, lb_dat_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    adr_d       = adr_q;
    remaining_d = remaining_q;
    index_d     = index_q;
    lb_we_d     = 1'b0;
    lb_adr_d    = lb_adr_q;
    lb_dat_d    = lb_dat_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;

    case (state_q)
      S_IDLE: begin
        // A start during active display would race the feeder, so drop it.
        if (start_i && !scanline_en_i) begin
          adr_d       = base_i;
          remaining_d = words_i;
          index_d     = '0;
          underrun_d  = 1'b0;
          if (words_i != '0) begin
            bus_d   = 1'b1;
            state_d = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_FETCH: begin
        if (scanline_en_i) begin
          bus_d      = 1'b0;
          underrun_d = 1'b1;
          state_d    = S_IDLE;
        end else if (m_ack_i) begin
          lb_we_d     = 1'b1;
          lb_adr_d    = index_q;
          lb_dat_d    = m_dat_i;
          index_d     = index_q + LBAW'(1);
          adr_d       = adr_q + AW'(1);
          remaining_d = remaining_q - (LBAW+1)'(1);
          if (remaining_q == (LBAW+1)'(1)) begin
            bus_d   = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        bus_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge dotclk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      bus_q       <= 1'b0;
      adr_q       <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      lb_we_q     <= 1'b0;
      lb_adr_q    <= '0;
      lb_dat_q    <= '0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      adr_q       <= adr_d;
      remaining_q <= remaining_d;
      index_q     <= index_d;
      lb_we_q     <= lb_we_d;
      lb_adr_q    <= lb_adr_d;
      lb_dat_q    <= lb_dat_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
    end
  end

  assign m_cyc_o    = bus_q;
  assign m_stb_o    = bus_q;
  assign busy_o     = bus_q;
  assign m_adr_o    = adr_q;
  assign lb_we_o    = lb_we_q;
  assign lb_adr_o   = lb_adr_q;
  assign lb_dat_o   = lb_dat_q;
  assign done_o     = done_q;
  assign underrun_o = underrun_q;

endmodule

`default_nettype wire
